board_renderer: RTL and testbench

//  Downstream drawing stage for Wild Misere Tic Tac Toe. Consumes one committed move
//  (square 1-9 plus symbol) from game control and rasterises a 16x16 X/O/blank sprite

---
 rtl/ttt_pkg.sv | 35 +++
 rtl/ttt_sprite_px.sv | 37 +++
 rtl/board_renderer.sv | 216 +++++++++++++++++++++
 tb/tb_board_renderer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared encodings, colours, board geometry and FSM states for the tic-tac-toe renderer.
// Optional grid drawing after reset is enabled by defining GRID_DRAW_EN.
package ttt_pkg;

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_X    = 2'b01;
  localparam logic [1:0] SYM_O    = 2'b10;
  localparam logic [1:0] SYM_BAD  = 2'b11;

  localparam logic [2:0] COL_X    = 3'b100;
  localparam logic [2:0] COL_O    = 3'b001;
  localparam logic [2:0] COL_BG   = 3'b000;
  localparam logic [2:0] COL_GRID = 3'b111;

  localparam int unsigned X0       = 24;
  localparam int unsigned Y0       = 4;
  localparam int unsigned CELL     = 36;
  localparam int unsigned LINE     = 2;
  localparam int unsigned SPR      = 16;
  localparam int unsigned PITCH    = CELL + LINE;
  localparam int unsigned INSET    = (CELL - SPR) / 2;
  localparam int unsigned GRID_LEN = 3 * CELL + 2 * LINE;
  localparam int unsigned GRID_SEG = LINE * GRID_LEN;

  typedef enum logic [2:0] {StIdle, StGrid, StDraw, StDone, StRej} state_e;

  function automatic logic [7:0] cell_ox(input logic [1:0] col);
    return 8'(X0 + int'(col) * PITCH + INSET);
  endfunction

  function automatic logic [6:0] cell_oy(input logic [1:0] row);
    return 7'(Y0 + int'(row) * PITCH + INSET);
  endfunction

endpackage

// File: rtl/ttt_sprite_px.sv
// Combinational 16x16 sprite lookup: returns whether pixel (row, col) is set for a symbol.
module ttt_sprite_px
  import ttt_pkg::*;
(
  input  logic [3:0] i_row,
  input  logic [3:0] i_col,
  input  logic [1:0] i_sym,
  output logic       o_pixel_on
);

  logic [4:0] w_diff;
  logic [4:0] w_sum;
  logic       w_x_on;
  logic       w_o_on;
  logic       w_edge_r, w_edge_c, w_mid_r, w_mid_c;

  // Difference taken mod 32, so |i-j|<=1 is {0, 1, 31}.
  assign w_diff   = {1'b0, i_row} - {1'b0, i_col};
  assign w_sum    = {1'b0, i_row} + {1'b0, i_col};
  assign w_x_on   = (w_diff == 5'd0) || (w_diff == 5'd1) || (w_diff == 5'd31) ||
                    ((w_sum >= 5'd14) && (w_sum <= 5'd16));
  assign w_edge_r = (i_row <= 4'd1) || (i_row >= 4'd14);
  assign w_edge_c = (i_col <= 4'd1) || (i_col >= 4'd14);
  assign w_mid_r  = !w_edge_r;
  assign w_mid_c  = !w_edge_c;
  assign w_o_on   = (w_edge_r && w_mid_c) || (w_edge_c && w_mid_r);

  always_comb begin
    o_pixel_on = 1'b0;
    case (i_sym)
      SYM_X:   o_pixel_on = w_x_on;
      SYM_O:   o_pixel_on = w_o_on;
      default: o_pixel_on = 1'b0;
    endcase
  end

endmodule

// File: rtl/board_renderer.sv
// Rasterises one X/O/blank sprite per request into a board cell via the VGA pixel port.
// Define GRID_DRAW_EN to draw the four grid lines once after reset release.
module board_renderer
  import ttt_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       draw_req,
  input  logic [3:0] pos,
  input  logic [1:0] sym,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);

`ifdef GRID_DRAW_EN
  localparam state_e ResetState = StGrid;
`else
  localparam state_e ResetState = StIdle;
`endif

  state_e     r_state, w_state_next;
  logic [7:0] r_k, w_k_next;
  logic [7:0] r_ox, w_ox_next;
  logic [6:0] r_oy, w_oy_next;
  logic [1:0] r_sym, w_sym_next;
  logic [7:0] r_x, w_x_next;
  logic [6:0] r_y, w_y_next;
  logic [2:0] r_colour, w_colour_next;
  logic       r_plot, w_plot_next;
  logic       r_done, w_done_next;
  logic       r_err, w_err_next;
  logic [1:0] w_col, w_row;
  logic       w_pos_ok;
  logic       w_px_on;
  logic       w_grid;
  logic [7:0] w_gx;
  logic [6:0] w_gy;

  always_comb begin
    w_pos_ok = 1'b1;
    w_col    = 2'd0;
    w_row    = 2'd0;
    case (pos)
      4'd1:    begin w_col = 2'd0; w_row = 2'd0; end
      4'd2:    begin w_col = 2'd1; w_row = 2'd0; end
      4'd3:    begin w_col = 2'd2; w_row = 2'd0; end
      4'd4:    begin w_col = 2'd0; w_row = 2'd1; end
      4'd5:    begin w_col = 2'd1; w_row = 2'd1; end
      4'd6:    begin w_col = 2'd2; w_row = 2'd1; end
      4'd7:    begin w_col = 2'd0; w_row = 2'd2; end
      4'd8:    begin w_col = 2'd1; w_row = 2'd2; end
      4'd9:    begin w_col = 2'd2; w_row = 2'd2; end
      default: w_pos_ok = 1'b0;
    endcase
  end

`ifdef GRID_DRAW_EN
  logic [9:0] r_g, w_g_next;
  logic [7:0] w_gm;
  logic [1:0] w_seg;
  logic [6:0] w_along;

  // Each line is LINE px thick; the low bit of the in-segment count picks the thickness row.
  always_comb begin
    w_seg = 2'd0;
    w_gm  = r_g[7:0];
    if (r_g < 10'(GRID_SEG)) begin
      w_seg = 2'd0; w_gm = 8'(r_g);
    end else if (r_g < 10'(2 * GRID_SEG)) begin
      w_seg = 2'd1; w_gm = 8'(r_g - 10'(GRID_SEG));
    end else if (r_g < 10'(3 * GRID_SEG)) begin
      w_seg = 2'd2; w_gm = 8'(r_g - 10'(2 * GRID_SEG));
    end else begin
      w_seg = 2'd3; w_gm = 8'(r_g - 10'(3 * GRID_SEG));
    end
    w_along = w_gm[7:1];
    w_gx    = 8'(X0) + {1'b0, w_along};
    w_gy    = 7'(Y0) + w_along;
    case (w_seg)
      2'd0:    w_gx = 8'(X0 + CELL) + {7'd0, w_gm[0]};
      2'd1:    w_gx = 8'(X0 + CELL + PITCH) + {7'd0, w_gm[0]};
      2'd2:    w_gy = 7'(Y0 + CELL) + {6'd0, w_gm[0]};
      default: w_gy = 7'(Y0 + CELL + PITCH) + {6'd0, w_gm[0]};
    endcase
  end
`else
  assign w_gx = 8'd0;
  assign w_gy = 7'd0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    w_ox_next    = r_ox;
    w_oy_next    = r_oy;
    w_sym_next   = r_sym;
    w_plot_next  = 1'b0;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    w_grid       = 1'b0;
`ifdef GRID_DRAW_EN
    w_g_next     = r_g;
`endif
    case (r_state)
      StIdle: begin
        if (draw_req) begin
          if (!w_pos_ok || (sym == SYM_BAD)) begin
            w_state_next = StRej;
            w_err_next   = 1'b1;
          end else begin
            w_state_next = StDraw;
            w_k_next     = 8'd0;
            w_ox_next    = cell_ox(w_col);
            w_oy_next    = cell_oy(w_row);
            w_sym_next   = sym;
            w_plot_next  = 1'b1;
          end
        end
      end
      StDraw: begin
        if (r_k == 8'hff) begin
          w_state_next = StDone;
          w_done_next  = 1'b1;
        end else begin
          w_k_next    = r_k + 8'd1;
          w_plot_next = 1'b1;
        end
      end
`ifdef GRID_DRAW_EN
      StGrid: begin
        if (r_g == 10'(4 * GRID_SEG)) begin
          w_state_next = StIdle;
        end else begin
          w_plot_next = 1'b1;
          w_grid      = 1'b1;
          w_g_next    = r_g + 10'd1;
        end
      end
`endif
      default: w_state_next = StIdle;
    endcase
  end

  ttt_sprite_px u_sprite (
    .i_row      (w_k_next[7:4]),
    .i_col      (w_k_next[3:0]),
    .i_sym      (w_sym_next),
    .o_pixel_on (w_px_on)
  );

  // Pixel port is computed from next-state values so it is registered alongside the counter.
  always_comb begin
    w_x_next      = 8'd0;
    w_y_next      = 7'd0;
    w_colour_next = COL_BG;
    if (w_plot_next) begin
      if (w_grid) begin
        w_x_next      = w_gx;
        w_y_next      = w_gy;
        w_colour_next = COL_GRID;
      end else begin
        w_x_next      = w_ox_next + {4'd0, w_k_next[3:0]};
        w_y_next      = w_oy_next + {3'd0, w_k_next[7:4]};
        w_colour_next = !w_px_on ? COL_BG : ((w_sym_next == SYM_O) ? COL_O : COL_X);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ResetState;
      r_k      <= 8'd0;
      r_ox     <= 8'd0;
      r_oy     <= 7'd0;
      r_sym    <= SYM_NONE;
      r_x      <= 8'd0;
      r_y      <= 7'd0;
      r_colour <= COL_BG;
      r_plot   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef GRID_DRAW_EN
      r_g      <= 10'd0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_k      <= w_k_next;
      r_ox     <= w_ox_next;
      r_oy     <= w_oy_next;
      r_sym    <= w_sym_next;
      r_x      <= w_x_next;
      r_y      <= w_y_next;
      r_colour <= w_colour_next;
      r_plot   <= w_plot_next;
      r_done   <= w_done_next;
      r_err    <= w_err_next;
`ifdef GRID_DRAW_EN
      r_g      <= w_g_next;
`endif
    end
  end

  assign busy   = (r_state != StIdle);
  assign done   = r_done;
  assign err    = r_err;
  assign x      = r_x;
  assign y      = r_y;
  assign colour = r_colour;
  assign plot   = r_plot;

endmodule

// File: tb/tb_board_renderer.sv
// Directed self-checking bench for board_renderer (sprite raster, reject, hold, abort).
module tb_board_renderer;

  logic       clock;
  logic       resetn;
  logic       draw_req;
  logic [3:0] pos;
  logic [1:0] sym;
  logic       busy, done, err, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  int checks = 0;
  int errors = 0;

  board_renderer dut (
    .clock    (clock),
    .resetn   (resetn),
    .draw_req (draw_req),
    .pos      (pos),
    .sym      (sym),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Reference sprite colour straight from the |i-j| / |i+j-15| and ring definitions.
  function automatic logic [2:0] exp_col(input int i, input int j, input logic [1:0] s);
    int  d, e;
    bit  on;
    d = i - j;  if (d < 0) d = -d;
    e = i + j - 15;  if (e < 0) e = -e;
    on = 1'b0;
    if (s == 2'b01) on = (d <= 1) || (e <= 1);
    if (s == 2'b10) on = (((i <= 1) || (i >= 14)) && (j >= 2) && (j <= 13)) ||
                         (((j <= 1) || (j >= 14)) && (i >= 2) && (i <= 13));
    if (!on) return 3'b000;
    return (s == 2'b01) ? 3'b100 : 3'b001;
  endfunction

  task automatic test_reset;
    resetn = 1'b0; draw_req = 1'b0; pos = 4'd0; sym = 2'b00;
    #3;
    checks++;
    if ({plot, done, err, x, y, colour} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got plot=%b done=%b err=%b x=%0d y=%0d col=%b exp all 0",
               plot, done, err, x, y, colour);
    end
`ifndef GRID_DRAW_EN
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
`endif
    @(negedge clock);
    resetn = 1'b1;
    tick;
`ifndef GRID_DRAW_EN
    checks++;
    if ({busy, plot} !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset got busy=%b plot=%b exp 0 0", busy, plot);
    end
`endif
  endtask

`ifdef GRID_DRAW_EN
  task automatic test_grid;
    int n = 0;
    int cyc = 0;
    draw_req = 1'b1; pos = 4'd5; sym = 2'b01;
    while (busy && cyc < 1000) begin
      if (plot) begin
        if (n == 0) begin
          checks++;
          if ({x, y, colour} !== {8'd60, 7'd4, 3'b111}) begin
            errors++; $display("FAIL grid_first got (%0d,%0d)=%b exp (60,4)=111", x, y, colour);
          end
        end
        if (n == 895) begin
          checks++;
          if ({x, y, colour} !== {8'd135, 7'd79, 3'b111}) begin
            errors++; $display("FAIL grid_last got (%0d,%0d)=%b exp (135,79)=111", x, y, colour);
          end
        end
        n++;
      end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL grid_done got 1 exp 0"); end
      tick;
      cyc++;
    end
    checks++;
    if (n != 896) begin errors++; $display("FAIL grid_plots got %0d exp 896", n); end
    draw_req = 1'b0;
    tick; tick; tick;
  endtask
`endif

  // Shared by sprite tests: assumes c1 has just been reached; walks c1..c258.
  task automatic run_raster(input string name, input logic [7:0] ox, input logic [6:0] oy,
                            input logic [1:0] s);
    for (int k = 0; k < 256; k++) begin
      if (k > 0) tick;
      checks++;
      if ({plot, busy, done, x, y, colour} !==
          {1'b1, 1'b1, 1'b0, ox + 8'(k % 16), oy + 7'(k / 16), exp_col(k / 16, k % 16, s)}) begin
        errors++;
        $display("FAIL %s_pix k=%0d got p=%b b=%b d=%b (%0d,%0d)=%b exp (%0d,%0d)=%b", name, k,
                 plot, busy, done, x, y, colour, ox + 8'(k % 16), oy + 7'(k / 16),
                 exp_col(k / 16, k % 16, s));
      end
    end
    tick;
    checks++;
    if ({done, plot, busy} !== 3'b101) begin
      errors++; $display("FAIL %s_done got d=%b p=%b b=%b exp 1 0 1", name, done, plot, busy);
    end
    tick;
    checks++;
    if ({done, plot, busy} !== 3'b000) begin
      errors++; $display("FAIL %s_idle got d=%b p=%b b=%b exp 0 0 0", name, done, plot, busy);
    end
  endtask

  task automatic test_draw_x_center;
    pos = 4'd5; sym = 2'b01; draw_req = 1'b1;
    tick;
    draw_req = 1'b0;
    checks++;
    if ({plot, x, y, colour} !== {1'b1, 8'd72, 7'd52, 3'b100}) begin
      errors++; $display("FAIL x_c1 got p=%b (%0d,%0d)=%b exp 1 (72,52)=100", plot, x, y, colour);
    end
    tick;
    checks++;
    if ({x, y, colour} !== {8'd73, 7'd52, 3'b100}) begin
      errors++; $display("FAIL x_k1 got (%0d,%0d)=%b exp (73,52)=100", x, y, colour);
    end
    tick;
    checks++;
    if ({x, y, colour} !== {8'd74, 7'd52, 3'b000}) begin
      errors++; $display("FAIL x_k2 got (%0d,%0d)=%b exp (74,52)=000", x, y, colour);
    end
    tick;
    checks++;
    if ({x, y, colour} !== {8'd75, 7'd52, 3'b000}) begin
      errors++; $display("FAIL x_k3 got (%0d,%0d)=%b exp (75,52)=000", x, y, colour);
    end
    // Second full pass gives the complete raster check.
    pos = 4'd5; sym = 2'b01; draw_req = 1'b0;
    while (busy) tick;
    draw_req = 1'b1;
    tick;
    draw_req = 1'b0;
    run_raster("x5", 8'd72, 7'd52, 2'b01);
  endtask

  task automatic test_draw_o_corner;
    pos = 4'd9; sym = 2'b10; draw_req = 1'b1;
    tick;
    draw_req = 1'b0;
    checks++;
    if ({x, y, colour} !== {8'd110, 7'd90, 3'b000}) begin
      errors++; $display("FAIL o_first got (%0d,%0d)=%b exp (110,90)=000", x, y, colour);
    end
    tick; tick;
    checks++;
    if ({x, y, colour} !== {8'd112, 7'd90, 3'b001}) begin
      errors++; $display("FAIL o_k2 got (%0d,%0d)=%b exp (112,90)=001", x, y, colour);
    end
    for (int k = 3; k < 256; k++) tick;
    checks++;
    if ({plot, x, y, colour} !== {1'b1, 8'd125, 7'd105, 3'b000}) begin
      errors++; $display("FAIL o_last got p=%b (%0d,%0d)=%b exp 1 (125,105)=000",
                         plot, x, y, colour);
    end
    tick; tick;
    pos = 4'd4; sym = 2'b10; draw_req = 1'b1;
    tick;
    draw_req = 1'b0;
    run_raster("o4", 8'd34, 7'd52, 2'b10);
  endtask

  task automatic test_erase;
    pos = 4'd1; sym = 2'b00; draw_req = 1'b1;
    tick;
    draw_req = 1'b0;
    run_raster("erase1", 8'd34, 7'd14, 2'b00);
  endtask

  task automatic test_reject;
    logic [3:0] rp [3];
    logic [1:0] rs [3];
    rp[0] = 4'd0;  rs[0] = 2'b01;
    rp[1] = 4'd10; rs[1] = 2'b10;
    rp[2] = 4'd3;  rs[2] = 2'b11;
    for (int v = 0; v < 3; v++) begin
      pos = rp[v]; sym = rs[v]; draw_req = 1'b1;
      tick;
      draw_req = 1'b0;
      checks++;
      if ({err, busy, plot, done} !== 4'b1100) begin
        errors++; $display("FAIL rej%0d_c1 got e=%b b=%b p=%b d=%b exp 1 1 0 0",
                           v, err, busy, plot, done);
      end
      tick;
      checks++;
      if ({err, busy, plot, done} !== 4'b0000) begin
        errors++; $display("FAIL rej%0d_c2 got e=%b b=%b p=%b d=%b exp 0 0 0 0",
                           v, err, busy, plot, done);
      end
    end
  endtask

  task automatic test_req_held;
    int n = 0;
    int cyc = 1;
    pos = 4'd7; sym = 2'b01; draw_req = 1'b1;
    tick;
    while (!done && cyc < 300) begin
      if (plot) n++;
      tick;
      cyc++;
    end
    checks++;
    if (n != 256 || cyc != 257) begin
      errors++; $display("FAIL held_first got plots=%0d done_cycle=%0d exp 256 257", n, cyc);
    end
    tick;
    checks++;
    if ({busy, plot} !== 2'b00) begin
      errors++; $display("FAIL held_gap got b=%b p=%b exp 0 0", busy, plot);
    end
    tick;
    checks++;
    if ({plot, x, y} !== {1'b1, 8'd34, 7'd90}) begin
      errors++; $display("FAIL held_restart got p=%b (%0d,%0d) exp 1 (34,90)", plot, x, y);
    end
    draw_req = 1'b0;
    n = 0; cyc = 0;
    while (!done && cyc < 300) begin
      if (plot) n++;
      tick;
      cyc++;
    end
    checks++;
    if (n != 256 || !done) begin
      errors++; $display("FAIL held_second got plots=%0d done=%b exp 256 1", n, done);
    end
    tick;
  endtask

  task automatic test_reset_mid_draw;
    pos = 4'd5; sym = 2'b01; draw_req = 1'b1;
    tick;
    draw_req = 1'b0;
    for (int c = 1; c < 100; c++) tick;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, plot, x, y, colour} !== 22'd0) begin
      errors++; $display("FAIL abort_async got b=%b d=%b p=%b (%0d,%0d)=%b exp all 0",
                         busy, done, plot, x, y, colour);
    end
    tick; tick;
    @(negedge clock);
    resetn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      checks++;
      if ({done, plot, busy} !== 3'b000) begin
        errors++; $display("FAIL abort_quiet got d=%b p=%b b=%b exp 0 0 0", done, plot, busy);
      end
    end
    pos = 4'd2; sym = 2'b10; draw_req = 1'b1;
    tick;
    draw_req = 1'b0;
    run_raster("redraw2", 8'd72, 7'd14, 2'b10);
  endtask

  initial begin
    test_reset;
`ifdef GRID_DRAW_EN
    test_grid;
`endif
    test_draw_x_center;
    test_draw_o_corner;
    test_erase;
    test_reject;
    test_req_held;
    test_reset_mid_draw;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
